// File: rtl/booth_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Signed operands are divided as magnitudes and the signs are fixed up at
// the end. The quotient truncates toward zero and the remainder takes the
// dividend's sign.
module booth_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, ZERO} state_t;

    state_t state, state_nx;

    logic             sd, sv;       // dividend / divisor were negative
    logic [WIDTH-1:0] q;            // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] m;            // divisor magnitude
    logic [WIDTH:0]   a;            // partial remainder
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_raw;      // raw dividend, returned on divide-by-zero

    // Magnitudes taken at capture time; the most negative value maps to
    // 2^(WIDTH-1), which is exact as an unsigned number.
    logic             sd_in, sv_in;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    // One restoring step: shift {A,Q} left and try subtracting M.
    logic [WIDTH+1:0] a_sh, trial;

    // Operand sign detection, magnitudes and the trial subtraction
    always_comb begin
        sd_in   = signed_mode & dividend[WIDTH-1];
        sv_in   = signed_mode & divisor[WIDTH-1];
        dvd_mag = sd_in ? -dividend : dividend;
        dvs_mag = sv_in ? -divisor  : divisor;
        a_sh    = {a, q[WIDTH-1]};
        trial   = a_sh - {2'b00, m};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (divisor == '0) ? ZERO : ITER;
            ITER: if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            ZERO: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sd          <= 1'b0;
            sv          <= 1'b0;
            q           <= '0;
            m           <= '0;
            a           <= '0;
            cnt         <= '0;
            dvd_raw     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sd      <= sd_in;
                        sv      <= sv_in;
                        q       <= dvd_mag;
                        m       <= dvs_mag;
                        a       <= '0;
                        cnt     <= CW'(WIDTH);
                        dvd_raw <= dividend;
                    end
                end
                ITER: begin
                    // Sign bit of the trial decides restore vs. keep.
                    if (!trial[WIDTH+1]) begin
                        a <= trial[WIDTH:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        a <= a_sh[WIDTH:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    quotient    <= (sd ^ sv) ? -q : q;
                    remainder   <= sd ? -a[WIDTH-1:0] : a[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= dvd_raw;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ITER) || (state == FIX);

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: the driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_booth_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, start, signed_mode;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    booth_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        return e;
    endfunction

    // Truncating reference using native integer division.
    function automatic exp_t model(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy;
        if (y == '0) begin
            e = mk('1, x, 1'b1);
        end else if (sm) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            e  = mk(W'(sx / sy), W'(sx % sy), 1'b0);
        end else begin
            e  = mk(x / y, x % y, 1'b0);
        end
        return e;
    endfunction

    // Monitor: compare on done, and track that outputs hold between dones.
    logic [W-1:0] lq, lr;
    logic         ldz;
    bit           stable = 1'b1;
    bit           armed  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lq = '0; lr = '0; ldz = 1'b0; stable = 1'b1; armed = 1'b1;
        end else if (armed) begin
            if (done) begin
                chk("hold_stable", 64'(stable), 64'd1);
                if (scb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got q=%0h r=%0h, expected no done", quotient, remainder);
                end else begin
                    e = scb.pop_front();
                    chk("quotient",    64'(quotient),    64'(e.q));
                    chk("remainder",   64'(remainder),   64'(e.r));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                end
                lq = quotient; lr = remainder; ldz = div_by_zero; stable = 1'b1;
            end else if ({quotient, remainder, div_by_zero} !== {lq, lr, ldz}) begin
                stable = 1'b0;
            end
        end
    end

    // One operation; inject=1 pulses a second start mid-ITER that must be ignored.
    task automatic run_op(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e, input bit inject);
        int lat, bcnt;
        signed_mode = sm; dividend = x; divisor = y; start = 1'b1;
        scb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom); signed_mode = $urandom_range(0, 1);
        lat = 0; bcnt = 0;
        if (busy) bcnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (inject && k == 5) begin
                start = 1'b1; signed_mode = 1'b0; dividend = 16'd50; divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin lat = k; break; end
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("latency",     64'(lat),  e.dz ? 64'd1 : 64'(W + 1));
        chk("busy_cycles", 64'(bcnt), e.dz ? 64'd0 : 64'(W + 1));
        @(posedge clk); #1;
        chk("done_single_pulse", 64'({done, busy}), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic sm;
        logic [W-1:0] x, y;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({quotient, remainder, busy, done, div_by_zero}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, expected values worked by hand
        run_op(1'b0, 16'd1000, 16'd7,  mk(16'd142,  16'd6,    1'b0), 1'b0);
        run_op(1'b1, 16'hFF9C, 16'd7,  mk(16'hFFF2, 16'hFFFE, 1'b0), 1'b0); // -100/7
        run_op(1'b1, 16'd100,  16'hFFF9, mk(16'hFFF2, 16'd2,  1'b0), 1'b0); // 100/-7
        run_op(1'b1, 16'hFF9C, 16'hFFF9, mk(16'd14, 16'hFFFE, 1'b0), 1'b0); // -100/-7
        run_op(1'b0, 16'h1234, 16'd0,  mk(16'hFFFF, 16'h1234, 1'b1), 1'b0);
        run_op(1'b0, 16'd10,   16'd3,  mk(16'd3,    16'd1,    1'b0), 1'b0);
        run_op(1'b1, 16'h8000, 16'hFFFF, mk(16'h8000, 16'd0,  1'b0), 1'b0);
        run_op(1'b0, 16'hFFFF, 16'd1,  mk(16'hFFFF, 16'd0,    1'b0), 1'b0);
        run_op(1'b0, 16'd5,    16'd9,  mk(16'd0,    16'd5,    1'b0), 1'b0);
        run_op(1'b1, 16'h8000, 16'd0,  mk(16'hFFFF, 16'h8000, 1'b1), 1'b0);
        run_op(1'b0, 16'd1000, 16'd7,  mk(16'd142,  16'd6,    1'b0), 1'b1); // mid-ITER start ignored

        // Reset in the middle of an operation: abandoned, no done.
        signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_op_reset", 64'({quotient, remainder, busy, done, div_by_zero}), 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);
        run_op(1'b0, 16'd1234, 16'd10, mk(16'd123, 16'd4, 1'b0), 1'b0);

        // Sweep against the reference model, both modes, some zero divisors
        for (int i = 0; i < 2000; i++) begin
            sm = $urandom_range(0, 1);
            x  = W'($urandom);
            y  = ($urandom_range(0, 31) == 0) ? '0 : W'($urandom >> $urandom_range(0, 16));
            if (i % 50 == 0) x = 16'h8000;
            run_op(sm, x, y, model(sm, x, y), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
